// File: rtl/rr_grant_scheduler_if.sv
// Request/grant bundle between the requesters (master) and rr_grant_scheduler (slave).
// The requester side drives req_i/done_i; the scheduler drives the grant outputs.
interface rr_grant_scheduler_if #(
  parameter int NUM_REQ = 4
);
  localparam int IDX_WIDTH = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_i;
  logic                 done_i;
  logic [NUM_REQ-1:0]   grant_o;
  logic [IDX_WIDTH-1:0] grant_idx_o;
  logic                 grant_valid_o;
  logic                 timeout_o;

  modport master (
    output req_i, done_i,
    input  grant_o, grant_idx_o, grant_valid_o, timeout_o
  );

  modport slave (
    input  req_i, done_i,
    output grant_o, grant_idx_o, grant_valid_o, timeout_o
  );
endinterface

// File: rtl/rr_grant_scheduler.sv
// Round-robin grant scheduler with a registered one-hot grant held until release.
// Define RR_GRANT_HOLD_TIMEOUT_EN to add a MAX_HOLD-cycle forced release with timeout_o.
module rr_grant_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  rr_grant_scheduler_if.slave   bus
);

  localparam int                   IDX_WIDTH = $clog2(NUM_REQ);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX  = IDX_WIDTH'(NUM_REQ - 1);
  localparam logic [IDX_WIDTH:0]   NUM_REQ_W = (IDX_WIDTH + 1)'(NUM_REQ);

  if (NUM_REQ < 2 || MAX_HOLD < 2) begin : g_param_check
    $error("rr_grant_scheduler: NUM_REQ and MAX_HOLD must both be >= 2");
  end

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t               state, state_d;
  logic [IDX_WIDTH-1:0] ptr, ptr_d, ptr_adv, search_ptr;
  logic [IDX_WIDTH-1:0] win_idx, cand;
  logic [IDX_WIDTH:0]   sum;
  logic [NUM_REQ-1:0]   win_onehot;
  logic                 any_req;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  logic                 valid_q, valid_d;
  logic                 release_normal, release_forced, release_any, load;

  // Pointer just past the current holder, so the holder becomes lowest priority.
  assign ptr_adv = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;

  // Winner search: the scan runs from the farthest offset down so that the
  // first set bit at or after search_ptr (modulo NUM_REQ) is the last write.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no latch can be inferred.
    search_ptr = (state == GRANT) ? ptr_adv : ptr;
    win_idx    = '0;
    sum        = '0;
    cand       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, search_ptr} + (IDX_WIDTH + 1)'(i);
      if (sum >= NUM_REQ_W) sum = sum - NUM_REQ_W;
      cand = sum[IDX_WIDTH-1:0];
      if (bus.req_i[cand]) win_idx = cand;
    end
    any_req    = |bus.req_i;
    win_onehot = any_req ? (NUM_REQ'(1) << win_idx) : '0;
  end

  always_comb begin
    release_normal = (state == GRANT) && (bus.done_i || !bus.req_i[idx_q]);
    release_any    = release_normal || release_forced;
    load           = (state == IDLE) ? any_req : release_any;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (any_req) state_d = GRANT;
      GRANT:   if (release_any && !any_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values
  always_comb begin
    ptr_d   = ptr;
    grant_d = grant_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    if (release_any) ptr_d = ptr_adv;
    if (load) begin
      grant_d = win_onehot;
      idx_d   = win_idx;
      valid_d = any_req;
    end
  end

  // State register
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst_i) begin
      state   <= IDLE;
      ptr     <= '0;
      grant_q <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state   <= state_d;
      ptr     <= ptr_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
    end
  end

`ifdef RR_GRANT_HOLD_TIMEOUT_EN
  localparam int                HOLD_W    = $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

  logic [HOLD_W-1:0] hold_cnt;
  logic              timeout_q;

  // A normal release in the same cycle wins, so the forced path stays quiet.
  assign release_forced = (state == GRANT) && !release_normal && (hold_cnt == HOLD_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= release_forced;
      if (load)                hold_cnt <= '0;
      else if (state == GRANT) hold_cnt <= hold_cnt + 1'b1;
    end
  end

  assign bus.timeout_o = timeout_q;
`else
  assign release_forced = 1'b0;
  assign bus.timeout_o  = 1'b0;
`endif

  assign bus.grant_o       = grant_q;
  assign bus.grant_idx_o   = idx_q;
  assign bus.grant_valid_o = valid_q;

endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Directed bench for rr_grant_scheduler: a vector table on a 4-requester instance,
// plus hand sequences for 3-requester wrap, mid-grant reset and hold timeout.
module tb_rr_grant_scheduler;

  logic clk = 1'b0;
  logic rst4, rst3;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rr_grant_scheduler_if #(.NUM_REQ(4)) bus4 ();
  rr_grant_scheduler_if #(.NUM_REQ(3)) bus3 ();

  rr_grant_scheduler #(.NUM_REQ(4), .MAX_HOLD(4)) dut4 (
    .clk_i (clk),
    .rst_i (rst4),
    .bus   (bus4)
  );

  rr_grant_scheduler #(.NUM_REQ(3), .MAX_HOLD(4)) dut3 (
    .clk_i (clk),
    .rst_i (rst3),
    .bus   (bus3)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] idx;
    logic       valid;
  } vec_t;

  vec_t vecs[24];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check4(input string tag, input logic [3:0] g, input logic [1:0] i,
                        input logic v, input logic t);
    check({tag, ".grant"},   32'(bus4.grant_o),       32'(g));
    check({tag, ".idx"},     32'(bus4.grant_idx_o),   32'(i));
    check({tag, ".valid"},   32'(bus4.grant_valid_o), 32'(v));
    check({tag, ".timeout"}, 32'(bus4.timeout_o),     32'(t));
  endtask

  initial begin
    logic [1:0] seq101[4];
    logic [1:0] seq111[4];
    logic [2:0] onehot3;

    // T1 reset, T2 rotation, no preemption, sole-requester re-grant, idle done
    vecs[0]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0, 1'b0};
    vecs[2]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};
    vecs[3]  = '{1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1};
    vecs[4]  = '{1'b0, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1};
    vecs[5]  = '{1'b0, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1};
    vecs[6]  = '{1'b0, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1};
    vecs[7]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};
    vecs[8]  = '{1'b0, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1};
    vecs[9]  = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
    vecs[10] = '{1'b0, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0};
    // T3 sparse/drop
    vecs[11] = '{1'b1, 4'b1010, 1'b0, 4'b0000, 2'd0, 1'b0};
    vecs[12] = '{1'b0, 4'b1010, 1'b0, 4'b0010, 2'd1, 1'b1};
    vecs[13] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1};
    vecs[14] = '{1'b0, 4'b1000, 1'b0, 4'b1000, 2'd3, 1'b1};
    vecs[15] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0};
    // done and drop together count as a single release
    vecs[16] = '{1'b0, 4'b0110, 1'b0, 4'b0010, 2'd1, 1'b1};
    vecs[17] = '{1'b0, 4'b0100, 1'b1, 4'b0100, 2'd2, 1'b1};
    // T5 mid-grant reset on idx 2; next grant scans from ptr 0
    vecs[18] = '{1'b1, 4'b0100, 1'b0, 4'b0000, 2'd0, 1'b0};
    vecs[19] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 2'd0, 1'b1};
    vecs[20] = '{1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1};
    vecs[21] = '{1'b0, 4'b1101, 1'b0, 4'b0100, 2'd2, 1'b1};
    vecs[22] = '{1'b0, 4'b1001, 1'b1, 4'b1000, 2'd3, 1'b1};
    vecs[23] = '{1'b0, 4'b0011, 1'b0, 4'b0001, 2'd0, 1'b1};

    rst4 = 1'b1;
    rst3 = 1'b1;
    bus4.req_i  = '0;
    bus4.done_i = 1'b0;
    bus3.req_i  = '0;
    bus3.done_i = 1'b0;

    for (int k = 0; k < 24; k++) begin
      rst4        = vecs[k].rst;
      bus4.req_i  = vecs[k].req;
      bus4.done_i = vecs[k].done;
      step();
      check4($sformatf("v%0d", k), vecs[k].grant, vecs[k].idx, vecs[k].valid, 1'b0);
    end
    bus4.done_i = 1'b0;

    // T4 wrap on the 3-requester instance
    seq101 = '{2'd0, 2'd2, 2'd0, 2'd2};
    seq111 = '{2'd0, 2'd1, 2'd2, 2'd0};
    rst3 = 1'b1;
    bus3.req_i = 3'b101;
    step();
    check("wrap.reset_grant", 32'(bus3.grant_o), 32'd0);
    rst3 = 1'b0;
    for (int j = 0; j < 4; j++) begin
      bus3.done_i = (j != 0);
      step();
      onehot3 = 3'b001 << seq101[j];
      check($sformatf("wrap101[%0d].idx", j),   32'(bus3.grant_idx_o), 32'(seq101[j]));
      check($sformatf("wrap101[%0d].grant", j), 32'(bus3.grant_o),     32'(onehot3));
    end
    bus3.done_i = 1'b0;
    rst3 = 1'b1;
    bus3.req_i = 3'b111;
    step();
    rst3 = 1'b0;
    for (int j = 0; j < 4; j++) begin
      bus3.done_i = (j != 0);
      step();
      onehot3 = 3'b001 << seq111[j];
      check($sformatf("wrap111[%0d].idx", j),   32'(bus3.grant_idx_o), 32'(seq111[j]));
      check($sformatf("wrap111[%0d].grant", j), 32'(bus3.grant_o),     32'(onehot3));
    end
    bus3.done_i = 1'b0;

    // T6 hold behaviour with a single steady requester and no done pulses
    rst4 = 1'b1;
    bus4.req_i  = 4'b0001;
    bus4.done_i = 1'b0;
    step();
    rst4 = 1'b0;
`ifdef RR_GRANT_HOLD_TIMEOUT_EN
    for (int k = 0; k < 13; k++) begin
      step();
      check4($sformatf("tmo[%0d]", k), 4'b0001, 2'd0, 1'b1, (k > 0) && (k % 4 == 0));
    end
    // Normal release on the would-be timeout edge wins; the next hold then times out
    rst4 = 1'b1;
    bus4.req_i = 4'b0011;
    step();
    rst4 = 1'b0;
    step();
    check4("prec.grant0", 4'b0001, 2'd0, 1'b1, 1'b0);
    step();
    step();
    step();
    bus4.done_i = 1'b1;
    step();
    bus4.done_i = 1'b0;
    check4("prec.normal", 4'b0010, 2'd1, 1'b1, 1'b0);
    step();
    step();
    step();
    step();
    check4("prec.forced", 4'b0001, 2'd0, 1'b1, 1'b1);
`else
    for (int k = 0; k < 120; k++) begin
      step();
      check4($sformatf("hold[%0d]", k), 4'b0001, 2'd0, 1'b1, 1'b0);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
